stack_alu_sequencer: RTL and testbench
======================================

# stack_alu_sequencer

Program sequencer that sits directly upstream of the stack-based ALU. It holds a small loadable program of ALU instructions and, on `start`, issues one instruction per cycle on the ALU's `opcode`/`input_data` inputs. It tracks stack depth to catch underflow and overflow before issue, captures the ALU result after every POP, and accumulates a sticky arithmetic-overflow flag for the whole run.

## Interface
- `N`, 4: data width; must match the ALU's `n`.
- `DEPTH`, 16: program entries; `PW = clog2(DEPTH)`.
- `SDEPTH`, 16: ALU stack capacity, used for depth checking.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `prog_we` in 1: write strobe for program memory; ignored while `busy`.
- `prog_addr` in PW: write address.
- `prog_op` in 3: opcode to store.
- `prog_data` in N: push operand to store.
- `start` in 1: one-cycle pulse; honoured only in IDLE.
- `alu_opcode` out 3: to the ALU `opcode` input.
- `alu_data` out N: to the ALU `input_data` input.
- `alu_result` in N: from the ALU `output_data` output.
- `alu_overflow` in 1: from the ALU `overflow` output.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of run.
- `error` out 1: stack misuse detected; valid with `done`, held until next `start`.
- `ovf_sticky` out 1: OR of `alu_overflow` over all ADD/MUL results of the run.
- `result` out N: last POP value (signed); holds between POPs.
- `result_valid` out 1: one-cycle pulse per captured POP.
- `pc` out PW: current fetch address.

## Operation
- Opcodes:
  - NOP = 000
  - HALT = 001
  - ADD = 100
  - MUL = 101
  - PUSH = 110
  - POP = 111
- The ALU treats any opcode with MSB 0 as a no-op. NOP, HALT and idle cycles all drive `alu_opcode` = 000.
- FSM states:
  - IDLE → RUN on `start`. `pc`, `error` and `ovf_sticky` clear at this transition.
  - RUN fetches `mem[pc]`:
    - ADD/MUL require `depth` ≥ 2 and reduce `depth` by 1.
    - PUSH requires `depth` < SDEPTH and increases `depth` by 1.
    - POP requires `depth` ≥ 1 and decreases `depth` by 1.
    - NOP leaves `depth` unchanged.
    - `pc` then increments.
  - A failed check suppresses the issue (000 is driven instead), sets `error`, and moves RUN → DRAIN.
  - HALT moves RUN → DRAIN. Executing the entry at `pc` = DEPTH−1 is an implicit HALT afterwards; `pc` does not wrap.
  - DRAIN lasts exactly 2 cycles so the last POP/ADD/MUL result is captured, then moves to DONE.
  - DONE asserts `done` for 1 cycle, then returns to IDLE.
- `depth` is internal, PW+1 bits wide. It is cleared only by `rst`, not by `start`, because it mirrors the ALU stack, which persists across runs.
- Arithmetic is performed by the ALU. The sequencer does no arithmetic beyond `depth` and `pc`.
- Program memory is not reset; its contents survive `rst`.
- `start` while busy is ignored. `prog_we` and `start` in the same IDLE cycle: the write lands, and the run uses the new contents.

## Timing
- Reset values: `alu_opcode`=000, `alu_data`=0, `busy`=0, `done`=0, `error`=0, `ovf_sticky`=0, `result`=0, `result_valid`=0, `pc`=0, `depth`=0, state IDLE.
- `start` sampled at edge E puts the FSM in RUN from cycle E+1.
- Instruction fetched in cycle c:
  - It appears on `alu_opcode`/`alu_data` (registered) in cycle c+1, for exactly one cycle.
  - The ALU updates at the end of c+1.
  - The sequencer samples `alu_result`/`alu_overflow` at the end of c+2.
  - `result_valid` and any `ovf_sticky` update become visible in c+3.
- Throughput is one instruction per cycle with no stalls.
- Program of K instructions ending in HALT (HALT at index K): DRAIN covers cycles K+2 and K+3 after RUN entry, and `done` is high in the following cycle.
- `rst` mid-run: immediate return to IDLE with all outputs at their reset values. The ALU shares `rst`, so the two depths stay consistent.

## Structure
- Shared package/include `stack_alu_pkg` holds:
  - the opcode constants (shared with the ALU);
  - the FSM state encoding;
  - a width helper for PW.
- Sub-module `stack_alu_prog_mem`: DEPTH × (3+N) array, synchronous write, asynchronous read, no reset.

## Test plan
- PUSH 3, PUSH 2, MUL, POP, HALT → `result`=6, a single `result_valid` pulse, `ovf_sticky`=0, `error`=0.
- PUSH 7, PUSH 7, ADD, POP, HALT with N=4 → `result`=−2 (4'b1110), `ovf_sticky`=1.
- ADD on an empty stack → `error`=1 with `done`, `alu_opcode` never 100, `depth` stays 0.
- 17 PUSHes with SDEPTH=16 → exactly 16 PUSH issues, then `error`=1.
- `start` pulsed again mid-run, and `prog_we` mid-run → both ignored; memory unchanged after run.
- `rst` low during RUN → all outputs at reset values in that cycle; a rerun after reset gives correct results with retained program contents.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Definitions shared by the stack ALU and its program sequencer: opcodes,
// sequencer FSM encoding and the program-counter width helper.
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A one-entry program still needs a one-bit address.
    function automatic int pw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_alu_prog_mem.sv
// Instruction store of DEPTH {opcode, operand} words: synchronous write,
// combinational read so a fetch sees mem[pc] in the same cycle. Not reset.
module stack_alu_prog_mem #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [N+2:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [N+2:0]  rdata
);

    logic [N+2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_alu_sequencer.sv
// Program sequencer in front of the stack ALU: issues one stored instruction per
// cycle, blocks stack misuse before issue and captures POP results two cycles later.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int  N      = 4,
    parameter int  DEPTH  = 16,
    parameter int  SDEPTH = 16,
    localparam int PW     = pw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [2:0]    prog_op,
    input  logic [N-1:0]  prog_data,
    input  logic          start,
    output logic [2:0]    alu_opcode,
    output logic [N-1:0]  alu_data,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_overflow,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          ovf_sticky,
    output logic [N-1:0]  result,
    output logic          result_valid,
    output logic [PW-1:0] pc
);

    localparam logic [PW:0]   DEP_ONE = 1;
    localparam logic [PW:0]   DEP_TWO = 2;
    localparam logic [PW:0]   DEP_MAX = (PW+1)'(SDEPTH);
    localparam logic [PW-1:0] PC_ONE  = 1;
    localparam logic [PW-1:0] PC_LAST = PW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [PW:0]   depth, depth_nx;
    logic [PW-1:0] pc_nx;
    logic          drain_cnt, drain_nx;
    logic [2:0]    op_nx;
    logic [N-1:0]  data_nx;
    logic          err_set;
    logic          chk_ok;
    logic          start_run;
    logic [2:0]    op_p1;
    logic [N+2:0]  fetch;
    logic [2:0]    f_op;
    logic [N-1:0]  f_data;

    stack_alu_prog_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata ({prog_op, prog_data}),
        .raddr (pc),
        .rdata (fetch)
    );

    assign f_op      = fetch[N+2:N];
    assign f_data    = fetch[N-1:0];
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign start_run = (state == S_IDLE) && start;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        depth_nx = depth;
        drain_nx = drain_cnt;
        op_nx    = OP_NOP;
        data_nx  = '0;
        err_set  = 1'b0;
        chk_ok   = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    pc_nx    = '0;
                end
            end
            S_RUN: begin
                case (f_op)
                    OP_ADD, OP_MUL: begin
                        if (depth >= DEP_TWO) depth_nx = depth - DEP_ONE;
                        else                  chk_ok   = 1'b0;
                    end
                    OP_PUSH: begin
                        if (depth < DEP_MAX) depth_nx = depth + DEP_ONE;
                        else                 chk_ok   = 1'b0;
                    end
                    OP_POP: begin
                        if (depth >= DEP_ONE) depth_nx = depth - DEP_ONE;
                        else                  chk_ok   = 1'b0;
                    end
                    default: ;
                endcase
                // A rejected or halting fetch issues nothing and leaves pc on it.
                if (!chk_ok) begin
                    err_set  = 1'b1;
                    state_nx = S_DRAIN;
                    drain_nx = 1'b0;
                end else if (f_op == OP_HALT) begin
                    state_nx = S_DRAIN;
                    drain_nx = 1'b0;
                end else begin
                    op_nx   = f_op[2] ? f_op : OP_NOP;
                    data_nx = (f_op == OP_PUSH) ? f_data : '0;
                    if (pc == PC_LAST) begin
                        state_nx = S_DRAIN;
                        drain_nx = 1'b0;
                    end else begin
                        pc_nx = pc + PC_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt) begin
                    state_nx = S_DONE;
                    drain_nx = 1'b0;
                end else begin
                    drain_nx = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Fetch/issue stage: FSM, pc, depth mirror and registered ALU drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            depth      <= '0;
            drain_cnt  <= 1'b0;
            alu_opcode <= OP_NOP;
            alu_data   <= '0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            depth      <= depth_nx;
            drain_cnt  <= drain_nx;
            alu_opcode <= op_nx;
            alu_data   <= data_nx;
            if (start_run)    error <= 1'b0;
            else if (err_set) error <= 1'b1;
        end
    end

    // Capture stage: op_p1 lines up with the ALU output one cycle after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_p1        <= OP_NOP;
            result       <= '0;
            result_valid <= 1'b0;
            ovf_sticky   <= 1'b0;
        end else begin
            op_p1        <= alu_opcode;
            result_valid <= (op_p1 == OP_POP);
            if (op_p1 == OP_POP) begin
                result <= alu_result;
            end
            if (start_run) begin
                ovf_sticky <= 1'b0;
            end else if ((op_p1 == OP_ADD) || (op_p1 == OP_MUL)) begin
                ovf_sticky <= ovf_sticky | alu_overflow;
            end
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Randomised bench for stack_alu_sequencer: a behavioural ALU closes the loop and
// a queue-based program model predicts every cycle of each run.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int N      = 4;
    localparam int DEPTH  = 16;
    localparam int SDEPTH = 16;
    localparam int PW     = 4;
    localparam int VMAX   = (1 << (N - 1)) - 1;
    localparam int VMIN   = -(1 << (N - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [2:0]    prog_op = '0;
    logic [N-1:0]  prog_data = '0;
    logic          start = 1'b0;
    logic [2:0]    alu_opcode;
    logic [N-1:0]  alu_data;
    logic [N-1:0]  alu_result;
    logic          alu_overflow;
    logic          busy, done, error, ovf_sticky, result_valid;
    logic [N-1:0]  result;
    logic [PW-1:0] pc;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;

    always #5 clk = ~clk;

    stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .SDEPTH(SDEPTH)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_data(prog_data), .start(start),
        .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .busy(busy), .done(done), .error(error),
        .ovf_sticky(ovf_sticky), .result(result), .result_valid(result_valid), .pc(pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    // Behavioural stack ALU: registered output, shares the active-low reset.
    logic [N-1:0] alu_stk[$];

    task automatic alu_step();
        logic [N-1:0] a, b;
        int r;
        case (alu_opcode)
            OP_PUSH: if (alu_stk.size() < SDEPTH) alu_stk.push_back(alu_data);
            OP_POP:  if (alu_stk.size() > 0) alu_result <= alu_stk.pop_back();
            OP_ADD, OP_MUL: if (alu_stk.size() >= 2) begin
                a = alu_stk.pop_back();
                b = alu_stk.pop_back();
                r = (alu_opcode == OP_ADD) ? sx(a) + sx(b) : sx(a) * sx(b);
                alu_stk.push_back(r[N-1:0]);
                alu_result   <= r[N-1:0];
                alu_overflow <= (r > VMAX) || (r < VMIN);
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_stk.delete();
            alu_result   <= '0;
            alu_overflow <= 1'b0;
        end else begin
            alu_step();
        end
    end

    // Program image and reference model state.
    logic [2:0]   p_op   [DEPTH];
    logic [N-1:0] p_data [DEPTH];
    logic [N-1:0] ref_stk[$];
    logic [N-1:0] last_result = '0;

    logic [2:0]   e_op   [64];
    logic [N-1:0] e_data [64];
    logic [N-1:0] e_val  [64];
    logic [N-1:0] e_res  [64];
    bit           e_rv   [64];
    bit           e_ovset[64];
    bit           e_ovf  [64];
    bit           e_errc [64];
    bit           e_err;
    int           e_last, e_done;

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) begin
            p_op[i]   = OP_NOP;
            p_data[i] = '0;
        end
    endtask

    task automatic set_ins(input int i, input logic [2:0] op, input logic [N-1:0] d);
        p_op[i]   = op;
        p_data[i] = d;
    endtask

    task automatic load_prog(input bit skip0);
        for (int i = (skip0 ? 1 : 0); i < DEPTH; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = PW'(i);
            prog_op   = p_op[i];
            prog_data = p_data[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Walks the program against the reference stack; cycle 1 is the first RUN cycle.
    task automatic model_run();
        logic [N-1:0] a, b, v, cur;
        int  r;
        bit  stop, ov;
        for (int c = 0; c < 64; c++) begin
            e_op[c] = OP_NOP; e_data[c] = '0; e_val[c] = '0;
            e_rv[c] = 1'b0;   e_ovset[c] = 1'b0;
        end
        e_err  = 1'b0;
        stop   = 1'b0;
        e_last = DEPTH - 1;
        for (int i = 0; i < DEPTH && !stop; i++) begin
            e_last = i;
            case (p_op[i])
                OP_HALT: stop = 1'b1;
                OP_ADD, OP_MUL: begin
                    if (ref_stk.size() < 2) begin
                        e_err = 1'b1; stop = 1'b1;
                    end else begin
                        a = ref_stk.pop_back();
                        b = ref_stk.pop_back();
                        r = (p_op[i] == OP_ADD) ? sx(a) + sx(b) : sx(a) * sx(b);
                        ref_stk.push_back(r[N-1:0]);
                        e_op[i+2] = p_op[i];
                        if ((r > VMAX) || (r < VMIN)) e_ovset[i+4] = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (ref_stk.size() >= SDEPTH) begin
                        e_err = 1'b1; stop = 1'b1;
                    end else begin
                        ref_stk.push_back(p_data[i]);
                        e_op[i+2]   = OP_PUSH;
                        e_data[i+2] = p_data[i];
                    end
                end
                OP_POP: begin
                    if (ref_stk.size() == 0) begin
                        e_err = 1'b1; stop = 1'b1;
                    end else begin
                        v = ref_stk.pop_back();
                        e_op[i+2] = OP_POP;
                        e_rv[i+4] = 1'b1;
                        e_val[i+4] = v;
                    end
                end
                default: ;
            endcase
        end
        e_done = e_last + 4;
        cur = last_result;
        ov  = 1'b0;
        for (int c = 0; c <= e_done + 1; c++) begin
            if (e_rv[c]) cur = e_val[c];
            e_res[c]  = cur;
            ov        = ov | e_ovset[c];
            e_ovf[c]  = ov;
            e_errc[c] = e_err && (c >= e_last + 2);
        end
        last_result = cur;
    endtask

    task automatic run_prog(input bit disturb, input bit we_with_start);
        int a;
        model_run();
        @(negedge clk);
        start = 1'b1;
        if (we_with_start) begin
            prog_we = 1'b1; prog_addr = '0; prog_op = p_op[0]; prog_data = p_data[0];
        end
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        for (int c = 1; c <= e_done + 1; c++) begin
            chk($sformatf("done c%0d", c), 32'(done), 32'(c == e_done));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(c < e_done));
            chk($sformatf("opcode c%0d", c), 32'(alu_opcode), 32'(e_op[c]));
            if (e_op[c] == OP_PUSH) chk($sformatf("data c%0d", c), 32'(alu_data), 32'(e_data[c]));
            chk($sformatf("rvalid c%0d", c), 32'(result_valid), 32'(e_rv[c]));
            chk($sformatf("result c%0d", c), 32'(result), 32'(e_res[c]));
            chk($sformatf("ovf c%0d", c), 32'(ovf_sticky), 32'(e_ovf[c]));
            chk($sformatf("error c%0d", c), 32'(error), 32'(e_errc[c]));
            if (c <= e_last + 1) chk($sformatf("pc c%0d", c), 32'(pc), 32'(c - 1));
            if (alu_opcode == OP_PUSH) n_push++;
            if (disturb && c == 3) begin
                a = $urandom_range(0, DEPTH - 1);
                start = 1'b1; prog_we = 1'b1; prog_addr = PW'(a);
                prog_op = ~p_op[a]; prog_data = ~p_data[a];
            end
            @(posedge clk); #1;
            start = 1'b0; prog_we = 1'b0;
        end
    endtask

    function automatic logic [2:0] rand_op();
        int r = $urandom_range(0, 19);
        if (r < 7)  return OP_PUSH;
        if (r < 11) return OP_POP;
        if (r < 13) return OP_ADD;
        if (r < 15) return OP_MUL;
        if (r < 17) return OP_NOP;
        if (r < 18) return 3'b010;
        if (r < 19) return 3'b011;
        return OP_HALT;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " opcode"}, 32'(alu_opcode), 32'(OP_NOP));
        chk({tag, " data"},   32'(alu_data), 32'd0);
        chk({tag, " busy"},   32'(busy), 32'd0);
        chk({tag, " done"},   32'(done), 32'd0);
        chk({tag, " error"},  32'(error), 32'd0);
        chk({tag, " ovf"},    32'(ovf_sticky), 32'd0);
        chk({tag, " result"}, 32'(result), 32'd0);
        chk({tag, " rvalid"}, 32'(result_valid), 32'd0);
        chk({tag, " pc"},     32'(pc), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // 3 * 2 = 6
        clear_prog();
        set_ins(0, OP_PUSH, 4'd3); set_ins(1, OP_PUSH, 4'd2);
        set_ins(2, OP_MUL, 4'd0);  set_ins(3, OP_POP, 4'd0); set_ins(4, OP_HALT, 4'd0);
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);
        chk("mul result", 32'(result), 32'd6);
        chk("mul ovf", 32'(ovf_sticky), 32'd0);
        chk("mul error", 32'(error), 32'd0);

        // 7 + 7 wraps to -2 with overflow
        clear_prog();
        set_ins(0, OP_PUSH, 4'd7); set_ins(1, OP_PUSH, 4'd7);
        set_ins(2, OP_ADD, 4'd0);  set_ins(3, OP_POP, 4'd0); set_ins(4, OP_HALT, 4'd0);
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);
        chk("add result", 32'(result), 32'hE);
        chk("add ovf", 32'(ovf_sticky), 32'd1);

        // ADD on an empty stack
        clear_prog();
        set_ins(0, OP_ADD, 4'd0); set_ins(1, OP_HALT, 4'd0);
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);
        chk("underflow error", 32'(error), 32'd1);

        // 1 + 16 PUSHes against a 16-deep stack
        n_push = 0;
        clear_prog();
        set_ins(0, OP_PUSH, 4'd9); set_ins(1, OP_HALT, 4'd0);
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) set_ins(i, OP_PUSH, 4'(i));
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);
        chk("push issues", 32'(n_push), 32'd16);
        chk("overflow error", 32'(error), 32'd1);

        // Drain all 16 entries
        for (int i = 0; i < DEPTH; i++) set_ins(i, OP_POP, 4'd0);
        load_prog(1'b0);
        run_prog(1'b0, 1'b0);

        // start and prog_we while busy are ignored; rerun proves memory intact
        clear_prog();
        set_ins(0, OP_PUSH, 4'd5); set_ins(1, OP_POP, 4'd0); set_ins(2, OP_NOP, 4'd0);
        set_ins(3, OP_PUSH, 4'd2); set_ins(4, OP_POP, 4'd0); set_ins(5, OP_HALT, 4'd0);
        load_prog(1'b0);
        run_prog(1'b1, 1'b0);
        run_prog(1'b0, 1'b0);

        // Write landing in the same cycle as start
        set_ins(0, OP_PUSH, 4'd11);
        run_prog(1'b0, 1'b1);

        // Reset mid-run, then rerun with retained program
        clear_prog();
        set_ins(0, OP_PUSH, 4'd4); set_ins(1, OP_PUSH, 4'd3); set_ins(2, OP_ADD, 4'd0);
        set_ins(3, OP_POP, 4'd0);  set_ins(4, OP_HALT, 4'd0);
        load_prog(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrun rst");
        @(negedge clk);
        rst = 1'b1;
        ref_stk.delete();
        last_result = '0;
        run_prog(1'b0, 1'b0);
        chk("rerun result", 32'(result), 32'd7);

        // Random programs; stack contents carry over between runs
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < DEPTH; i++) set_ins(i, rand_op(), 4'($urandom));
            if (t[0]) begin
                load_prog(1'b1);
                run_prog(1'b0, 1'b1);
            end else begin
                load_prog(1'b0);
                run_prog(1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
